// File: rtl/trellis_bank_ctrl.sv
// Purpose: sequences the four survivor-memory banks and starts the two traceback units.
// Latency: bank controls follow counters/sel_in by 1 cycle; traceback controls trail the bank index by 3.
// Backpressure: none; free-running while enable is high, enable low restarts the frame.
module trellis_bank_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     sel_in,
    output logic [3:0]            wr_en_o,
    output logic [4*ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [1:0]            mem_bank_o,
    output logic                  frame_done_o,
    output logic [1:0]            tbu_en_o,
    output logic [1:0]            tbu_sel_o,
    output logic [7:0]            tbu_src_o
);

    localparam logic [1:0] BANK_A = 2'd0;
    localparam logic [1:0] BANK_B = 2'd1;
    localparam logic [1:0] BANK_C = 2'd2;
    localparam logic [1:0] BANK_D = 2'd3;

    logic [ADDR_W-1:0]   wr_cnt;
    logic [ADDR_W-1:0]   rd_cnt;
    logic [1:0]          mem_bank;
    logic [1:0]          mem_bank_q;
    logic [1:0]          mem_bank_q2;
    logic                wr_last;

    logic [3:0]          wr_en_nxt;
    logic [4*ADDR_W-1:0] addr_nxt;
    logic [1:0]          rel;
    logic [7:0]          tbu_src_nxt;
    logic [1:0]          tbu_sel_nxt;

    assign wr_last    = &wr_cnt;
    assign mem_bank_o = mem_bank;

    // Frame counters, bank rotation and the delayed bank-role pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt       <= '0;
            rd_cnt       <= '1;
            mem_bank     <= BANK_A;
            mem_bank_q   <= BANK_A;
            mem_bank_q2  <= BANK_A;
            frame_done_o <= 1'b0;
        end else if (!enable) begin
            wr_cnt       <= '0;
            rd_cnt       <= '1;
            mem_bank     <= BANK_A;
            mem_bank_q   <= BANK_A;
            mem_bank_q2  <= BANK_A;
            frame_done_o <= 1'b0;
        end else begin
            // rd_cnt counts down in lockstep so it always mirrors ~wr_cnt.
            wr_cnt       <= wr_cnt + 1'b1;
            rd_cnt       <= rd_cnt - 1'b1;
            if (wr_last) begin
                mem_bank <= mem_bank + 2'd1;
            end
            frame_done_o <= wr_last;
            mem_bank_q   <= mem_bank;
            mem_bank_q2  <= mem_bank_q;
        end
    end

    // Per-bank role decode relative to the current write bank.
    always_comb begin
        wr_en_nxt = '0;
        addr_nxt  = '0;
        rel       = '0;
        for (int i = 0; i < 4; i++) begin
            rel = 2'(i) - mem_bank;
            case (rel)
                2'd0: begin
                    wr_en_nxt[i]                    = 1'b1;
                    addr_nxt[i*ADDR_W +: ADDR_W]    = wr_cnt;
                end
                2'd2: begin
                    // idle bank parks at address 0
                    addr_nxt[i*ADDR_W +: ADDR_W]    = '0;
                end
                default: begin
                    addr_nxt[i*ADDR_W +: ADDR_W]    = rd_cnt;
                end
            endcase
        end
    end

    // Traceback source and selection from the twice-delayed bank index.
    always_comb begin
        tbu_src_nxt = '0;
        tbu_sel_nxt = '0;
        case (mem_bank_q2)
            2'd0: begin
                tbu_src_nxt = {BANK_B, BANK_C, BANK_C, BANK_D};
                tbu_sel_nxt = 2'b10;
            end
            2'd1: begin
                tbu_src_nxt = {BANK_D, BANK_A, BANK_C, BANK_D};
                tbu_sel_nxt = 2'b01;
            end
            2'd2: begin
                tbu_src_nxt = {BANK_D, BANK_A, BANK_A, BANK_B};
                tbu_sel_nxt = 2'b10;
            end
            default: begin
                tbu_src_nxt = {BANK_B, BANK_C, BANK_A, BANK_B};
                tbu_sel_nxt = 2'b01;
            end
        endcase
    end

    // Registered bank controls; write data is delayed with them so it lines up with wr_en_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_o <= '0;
            addr_o  <= '0;
            wdata_o <= '0;
        end else if (!enable) begin
            wr_en_o <= '0;
            addr_o  <= '0;
            wdata_o <= '0;
        end else begin
            wr_en_o <= wr_en_nxt;
            addr_o  <= addr_nxt;
            wdata_o <= sel_in;
        end
    end

    // Traceback controls; enables are sticky until restart and re-arm via the role pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbu_en_o  <= '0;
            tbu_src_o <= '0;
            tbu_sel_o <= '0;
        end else if (!enable) begin
            tbu_en_o  <= '0;
            tbu_src_o <= '0;
            tbu_sel_o <= '0;
        end else begin
            tbu_en_o  <= tbu_en_o | {(mem_bank_q2 == BANK_D), (mem_bank_q2 == BANK_C)};
            tbu_src_o <= tbu_src_nxt;
            tbu_sel_o <= tbu_sel_nxt;
        end
    end

endmodule

// File: tb/tb_trellis_bank_ctrl.sv
module tb_trellis_bank_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int F  = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DW-1:0]     sel_in;
    logic [3:0]        wr_en_o;
    logic [4*AW-1:0]   addr_o;
    logic [DW-1:0]     wdata_o;
    logic [1:0]        mem_bank_o;
    logic              frame_done_o;
    logic [1:0]        tbu_en_o;
    logic [1:0]        tbu_sel_o;
    logic [7:0]        tbu_src_o;

    trellis_bank_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sel_in       (sel_in),
        .wr_en_o      (wr_en_o),
        .addr_o       (addr_o),
        .wdata_o      (wdata_o),
        .mem_bank_o   (mem_bank_o),
        .frame_done_o (frame_done_o),
        .tbu_en_o     (tbu_en_o),
        .tbu_sel_o    (tbu_sel_o),
        .tbu_src_o    (tbu_src_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      wr_en;
        logic [4*AW-1:0] addr;
        logic [DW-1:0]   wdata;
        logic [1:0]      mem_bank;
        logic            frame_done;
        logic [1:0]      tbu_en;
        logic [7:0]      tbu_src;
        logic [1:0]      tbu_sel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: number of enabled edges since the last restart.
    int   k = 0;
    bit   t0f = 1'b0;
    bit   t1f = 1'b0;

    // Traceback table indexed by the twice-delayed bank (A=0..D=3).
    int t0d0[4] = '{3, 3, 1, 1};
    int t0d1[4] = '{2, 2, 0, 0};
    int t0s [4] = '{0, 1, 0, 1};
    int t1d0[4] = '{2, 0, 0, 2};
    int t1d1[4] = '{1, 3, 3, 1};
    int t1s [4] = '{1, 0, 1, 0};

    function automatic int bank_of(int m);
        if (m < 0) return 0;
        return (m / F) % 4;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs after one clock edge with the given sampled inputs.
    task automatic model_edge(bit r, bit en, logic [DW-1:0] s);
        exp_t e;
        int   prev, b, w, q2, rl;
        e = '0;
        if (r || !en) begin
            k   = 0;
            t0f = 1'b0;
            t1f = 1'b0;
        end else begin
            k++;
            prev    = k - 1;
            b       = bank_of(prev);
            w       = prev % F;
            e.wr_en = 4'(1 << b);
            for (int i = 0; i < 4; i++) begin
                rl = (i - b + 4) % 4;
                if (rl == 0)      e.addr[i*AW +: AW] = AW'(w);
                else if (rl == 2) e.addr[i*AW +: AW] = '0;
                else              e.addr[i*AW +: AW] = AW'(F - 1 - w);
            end
            e.wdata      = s;
            e.mem_bank   = 2'(bank_of(k));
            e.frame_done = ((k % F) == 0);
            q2 = bank_of(k - 3);
            if (q2 == 2) t0f = 1'b1;
            if (q2 == 3) t1f = 1'b1;
            e.tbu_en  = {t1f, t0f};
            e.tbu_src = {2'(t1d1[q2]), 2'(t1d0[q2]), 2'(t0d1[q2]), 2'(t0d0[q2])};
            e.tbu_sel = {t1s[q2] != 0, t0s[q2] != 0};
        end
        sb.push_back(e);
    endtask

    // Called one time unit after a rising edge; drives inputs for the next edge.
    task automatic step(bit r, bit en);
        logic [DW-1:0] s;
        s      = DW'($urandom);
        rst    = r;
        enable = en;
        sel_in = s;
        @(posedge clk);
        model_edge(r, en, s);
        #1;
    endtask

    task automatic check_reset_now(string tag);
        chk({tag, "_wr_en"},      64'(wr_en_o),      64'd0);
        chk({tag, "_addr"},       64'(addr_o),       64'd0);
        chk({tag, "_tbu_en"},     64'(tbu_en_o),     64'd0);
        chk({tag, "_mem_bank"},   64'(mem_bank_o),   64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done_o), 64'd0);
        chk({tag, "_tbu_src"},    64'(tbu_src_o),    64'd0);
        chk({tag, "_rd_cnt"},     64'(dut.rd_cnt),   64'(F - 1));
    endtask

    // Asynchronous reset pulse raised between edges, checked without a clock edge.
    task automatic async_pulse();
        #5;
        rst = 1'b1;
        #1;
        check_reset_now("async_rst");
        step(1'b1, 1'b1);
    endtask

    // Monitor: compare the DUT against the oldest expectation on every falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("wr_en",      64'(wr_en_o),      64'(mon_e.wr_en));
            chk("addr",       64'(addr_o),       64'(mon_e.addr));
            chk("wdata",      64'(wdata_o),      64'(mon_e.wdata));
            chk("mem_bank",   64'(mem_bank_o),   64'(mon_e.mem_bank));
            chk("frame_done", 64'(frame_done_o), 64'(mon_e.frame_done));
            chk("tbu_en",     64'(tbu_en_o),     64'(mon_e.tbu_en));
            chk("tbu_src",    64'(tbu_src_o),    64'(mon_e.tbu_src));
            chk("tbu_sel",    64'(tbu_sel_o),    64'(mon_e.tbu_sel));
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        sel_in = '0;
        #2;
        check_reset_now("por");
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Continuous run: first frame, rotations, both traceback starts, 3->0 wrap and beyond.
        for (int n = 0; n < 6 * F; n++) step(1'b0, 1'b1);

        // Drop enable at wr_cnt==5, then restart from bank A.
        while ((k % F) != 5) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int n = 0; n < 3 * F; n++) step(1'b0, 1'b1);

        // Async reset in the middle of a write, then power-on style restart.
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1);
        async_pulse();
        for (int n = 0; n < 5 * F; n++) step(1'b0, 1'b1);

        // Randomized run with occasional enable drops.
        for (int n = 0; n < 400; n++) step(1'b0, ($urandom_range(0, 39) != 0));
        for (int n = 0; n < 5 * F; n++) step(1'b0, 1'b1);

        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
